// File: rtl/multchan_pkg.sv
// multchan_pkg: shared constants, header field layout, RX state enum and length clamp.
// Optional feature macro: MULTCHAN_CHECKSUM_EN appends and checks a trailing XOR byte per frame.
package multchan_pkg;
  localparam int LEN_BIT = 5;
  localparam int HDR_CH_LSB = 5;
  localparam int HDR_LEN_LSB = 0;
`ifdef MULTCHAN_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif
  typedef enum logic [1:0] {RX_IDLE, RX_PAYLOAD, RX_HOLD} rx_state_t;
  function automatic logic [LEN_BIT-1:0] clamp_len(input logic [LEN_BIT-1:0] len, input int maxb);
    return int'(len) > maxb ? LEN_BIT'(maxb) : len;
  endfunction
endpackage

// File: rtl/multchan_rx_deframer.sv
// multchan_rx_deframer: pops bytes from the receiver, rebuilds frames, and holds one message per channel.
// Ports: clk, rst (async active-low); recv_data/recvable/recv_flag byte-receiver handshake;
// read_flag pops a channel slot; readable flags full slots; read_data shows the lowest full slot.
// MULTCHAN_CHECKSUM_EN: a trailing XOR byte is expected and mismatching frames are dropped.
module multchan_rx_deframer
  import multchan_pkg::*;
#(
  parameter int CHANNEL_BIT = 1,
  parameter int MESSAGE_BIT = 72
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      recv_data,
  input  logic                            recvable,
  output logic                            recv_flag,
  input  logic [(1<<CHANNEL_BIT)-1:0]     read_flag,
  output logic [(1<<CHANNEL_BIT)-1:0]     readable,
  output logic [LEN_BIT+MESSAGE_BIT-1:0]  read_data
);
  localparam int NCH = 1 << CHANNEL_BIT;
  localparam int MAXB = MESSAGE_BIT / 8;
  rx_state_t state;
  logic gap, is_cks, last, good, done, store;
  logic [CHANNEL_BIT-1:0] ch, dch;
  logic [LEN_BIT-1:0] len, dlen, cnt;
  logic [7:0] cks;
  logic [MESSAGE_BIT-1:0] data_q, nbuf;
  logic [LEN_BIT+MESSAGE_BIT-1:0] slot [NCH];
  // In IDLE the header byte itself supplies channel/length, so a zero-length frame completes on its pop.
  always_comb begin
    recv_flag = recvable & ~gap & (state != RX_HOLD);
    dch = state == RX_IDLE ? recv_data[HDR_CH_LSB +: CHANNEL_BIT] : ch;
    dlen = state == RX_IDLE ? recv_data[HDR_LEN_LSB +: LEN_BIT] : len;
    is_cks = CKS_EN && cnt == len;
    last = CKS_EN ? cnt == len : cnt + LEN_BIT'(1) == len;
    good = !(state == RX_PAYLOAD && is_cks) || recv_data == cks;
    done = state == RX_HOLD || recv_flag && (state == RX_IDLE ? !CKS_EN && dlen == '0 : last);
    store = done && good && (!readable[dch] || read_flag[dch]);
    nbuf = data_q;
    if (state == RX_IDLE)
      nbuf = '0;
    else if (recv_flag && state == RX_PAYLOAD && !is_cks && int'(cnt) < MAXB)
      nbuf[int'(cnt)*8 +: 8] = recv_data;
    read_data = '0;
    for (int c = NCH - 1; c >= 0; c--)
      if (readable[c]) read_data = slot[c];
  end
  // gap resets high so no byte is popped while rst is low and pops are spaced by a cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RX_IDLE;
      gap <= 1'b1;
      ch <= '0;
      len <= '0;
      cnt <= '0;
      cks <= '0;
      data_q <= '0;
      readable <= '0;
      for (int c = 0; c < NCH; c++) slot[c] <= '0;
    end else begin
      gap <= recv_flag;
      data_q <= nbuf;
      if (recv_flag && state == RX_IDLE) begin
        ch <= dch;
        len <= dlen;
        cnt <= '0;
        cks <= recv_data;
      end else if (recv_flag) begin
        cnt <= cnt + LEN_BIT'(1);
        cks <= cks ^ recv_data;
      end
      if (done) state <= good && !store ? RX_HOLD : RX_IDLE;
      else if (recv_flag) state <= RX_PAYLOAD;
      for (int c = 0; c < NCH; c++)
        if (store && dch == CHANNEL_BIT'(c)) begin
          readable[c] <= 1'b1;
          slot[c] <= {clamp_len(dlen, MAXB), nbuf};
        end else if (read_flag[c]) readable[c] <= 1'b0;
    end
  end
endmodule

// File: rtl/multchan_comm.sv
// multchan_comm: multiplexes per-channel messages over one byte stream as {ch,len} header + LE payload.
// Ports: clk, rst (async active-low); send_flag/send_data/sendable to the byte transmitter;
// recv_flag/recv_data/recvable from the byte receiver; write_flag/write_data/writable per-channel TX slots;
// read_flag/read_data/readable per-channel RX slots (read_data = lowest readable channel).
// MULTCHAN_CHECKSUM_EN: each frame carries a trailing XOR of header and payload bytes.
module multchan_comm
  import multchan_pkg::*;
#(
  parameter int CHANNEL_BIT = 1,
  parameter int MESSAGE_BIT = 72
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            send_flag,
  output logic [7:0]                      send_data,
  output logic                            recv_flag,
  input  logic [7:0]                      recv_data,
  input  logic                            sendable,
  input  logic                            recvable,
  input  logic [(1<<CHANNEL_BIT)-1:0]     read_flag,
  output logic [LEN_BIT+MESSAGE_BIT-1:0]  read_data,
  input  logic [(1<<CHANNEL_BIT)-1:0]     write_flag,
  input  logic [LEN_BIT+MESSAGE_BIT-1:0]  write_data,
  output logic [(1<<CHANNEL_BIT)-1:0]     readable,
  output logic [(1<<CHANNEL_BIT)-1:0]     writable
);
  localparam int NCH = 1 << CHANNEL_BIT;
  localparam int MAXB = MESSAGE_BIT / 8;
  localparam int W = LEN_BIT + MESSAGE_BIT;
  logic [NCH-1:0] full;
  logic [W-1:0] tx [NCH];
  logic busy, gap, pend, last;
  logic [CHANNEL_BIT-1:0] cur, pick;
  logic [LEN_BIT-1:0] len;
  logic [5:0] pos;
  logic [7:0] cks, tx_byte;
  // pos 0 is the header, 1..len the payload, len+1 the checksum byte when enabled.
  always_comb begin
    pick = '0;
    pend = 1'b0;
    for (int c = NCH - 1; c >= 0; c--)
      if (full[c]) begin
        pick = CHANNEL_BIT'(c);
        pend = 1'b1;
      end
    tx_byte = cks;
    if (pos == '0) tx_byte = {3'(cur), len};
    else if (pos <= {1'b0, len}) tx_byte = tx[cur][(int'(pos) - 1)*8 +: 8];
    last = pos == (CKS_EN ? {1'b0, len} + 6'd1 : {1'b0, len});
    send_flag = busy & sendable & ~gap;
    send_data = busy ? tx_byte : '0;
    writable = ~full;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= '0;
      busy <= 1'b0;
      gap <= 1'b0;
      cur <= '0;
      len <= '0;
      pos <= '0;
      cks <= '0;
      for (int c = 0; c < NCH; c++) tx[c] <= '0;
    end else begin
      gap <= send_flag;
      for (int c = 0; c < NCH; c++)
        if (write_flag[c] && !full[c]) begin
          full[c] <= 1'b1;
          tx[c] <= write_data;
        end else if (send_flag && last && cur == CHANNEL_BIT'(c)) full[c] <= 1'b0;
      if (!busy) begin
        busy <= pend;
        cur <= pick;
        len <= clamp_len(tx[pick][W-1 -: LEN_BIT], MAXB);
        pos <= '0;
        cks <= '0;
      end else if (send_flag) begin
        pos <= pos + 6'd1;
        cks <= cks ^ send_data;
        if (last) busy <= 1'b0;
      end
    end
  end
  multchan_rx_deframer #(.CHANNEL_BIT(CHANNEL_BIT), .MESSAGE_BIT(MESSAGE_BIT)) u_rx (
    .clk(clk),
    .rst(rst),
    .recv_data(recv_data),
    .recvable(recvable),
    .recv_flag(recv_flag),
    .read_flag(read_flag),
    .readable(readable),
    .read_data(read_data)
  );
endmodule

// File: tb/tb_multchan_comm.sv
// tb_multchan_comm: directed self-checking bench for multchan_comm (CHANNEL_BIT=1, MESSAGE_BIT=72).
module tb_multchan_comm;
  localparam int W = 77;
  logic clk = 1'b0, rst = 1'b0;
  logic send_flag, recv_flag, sendable, recvable;
  logic [7:0] send_data, recv_data;
  logic [1:0] read_flag, write_flag, readable, writable;
  logic [W-1:0] read_data, write_data;
  int checks = 0, errors = 0;
  logic [7:0] rxmem [256];
  logic [7:0] txlog [256];
  int wr_ptr = 0, rd_ptr = 0, tx_n = 0, base = 0;
  logic sf_prev = 1'b0, rf_prev = 1'b0;
  logic [7:0] exp_b [6];
  always #5 clk = ~clk;
  multchan_comm dut (
    .clk(clk), .rst(rst), .send_flag(send_flag), .send_data(send_data), .recv_flag(recv_flag),
    .recv_data(recv_data), .sendable(sendable), .recvable(recvable), .read_flag(read_flag),
    .read_data(read_data), .write_flag(write_flag), .write_data(write_data), .readable(readable),
    .writable(writable)
  );
  assign recvable = wr_ptr != rd_ptr;
  assign recv_data = rxmem[rd_ptr[7:0]];
  always @(posedge clk) begin
    if (recv_flag) rd_ptr <= rd_ptr + 1;
    if (send_flag) begin
      txlog[tx_n[7:0]] <= send_data;
      tx_n <= tx_n + 1;
    end
  end
  always @(negedge clk)
    if (rst) begin
      checks++;
      assert (!(send_flag && (sf_prev || !sendable)) && !(recv_flag && (rf_prev || !recvable))) else begin
        errors++;
        $error("FAIL handshake: send_flag=%b recv_flag=%b prev=%b/%b", send_flag, recv_flag, sf_prev, rf_prev);
      end
      sf_prev = send_flag;
      rf_prev = recv_flag;
    end else begin
      sf_prev = 1'b0;
      rf_prev = 1'b0;
    end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input logic [7:0] b);
    rxmem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask
  task automatic write(input logic [1:0] m, input logic [W-1:0] d);
    write_flag = m;
    write_data = d;
    tick();
    write_flag = '0;
  endtask
  task automatic read(input logic [1:0] m);
    read_flag = m;
    tick();
    read_flag = '0;
  endtask
  task automatic wait_tx(input int n, input string tag);
    int k = 0;
    while (tx_n < n && k < 300) begin
      tick();
      k++;
    end
    chk(tag, 128'(tx_n >= n), 128'(1));
  endtask
  task automatic wait_rd(input logic [1:0] m, input string tag);
    int k = 0;
    while (readable !== m && k < 300) begin
      tick();
      k++;
    end
    chk(tag, 128'(readable), 128'(m));
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    sendable = 1'b1;
    read_flag = '0;
    write_flag = '0;
    write_data = '0;
    tick(3);
    chk("rst send_flag", 128'(send_flag), 0);
    chk("rst send_data", 128'(send_data), 0);
    chk("rst recv_flag", 128'(recv_flag), 0);
    chk("rst readable", 128'(readable), 0);
    chk("rst read_data", 128'(read_data), 0);
    chk("rst writable", 128'(writable), 128'(2'b11));
    rst = 1'b1;
    tick(2);
    // Single TX frame on channel 1
    write(2'b10, {5'd4, 72'hDEADBEEF});
    chk("tx1 writable drop", 128'(writable), 128'(2'b01));
    wait_tx(5, "tx1 bytes");
    chk("tx1 writable rise", 128'(writable), 128'(2'b11));
    exp_b = '{8'h24, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
    for (int i = 0; i < 5; i++) chk($sformatf("tx1 byte%0d", i), 128'(txlog[i]), 128'(exp_b[i]));
    tick(8);
    chk("tx1 no extra", 128'(tx_n), 128'(5));
    // Same-cycle writes: channel 0 frame completes before channel 1 starts
    base = tx_n;
    write(2'b11, {5'd2, 72'hBBAA});
    wait_tx(base + 6, "arb bytes");
    exp_b = '{8'h02, 8'hAA, 8'hBB, 8'h22, 8'hAA, 8'hBB};
    for (int i = 0; i < 6; i++) chk($sformatf("arb byte%0d", i), 128'(txlog[base + i]), 128'(exp_b[i]));
    // Transmitter stalled; write to a full slot is ignored
    base = tx_n;
    sendable = 1'b0;
    write(2'b01, {5'd1, 72'h5A});
    write(2'b01, {5'd1, 72'h77});
    chk("stall writable", 128'(writable), 128'(2'b10));
    tick(6);
    chk("stall no send", 128'(tx_n), 128'(base));
    sendable = 1'b1;
    wait_tx(base + 2, "stall bytes");
    chk("stall hdr", 128'(txlog[base]), 128'(8'h01));
    chk("stall payload", 128'(txlog[base + 1]), 128'(8'h5A));
    tick(10);
    chk("full write ignored", 128'(tx_n), 128'(base + 2));
    // RX basic frame
    push(8'h05); push(8'h78); push(8'h56); push(8'h34); push(8'h12); push(8'h00);
    wait_rd(2'b01, "rx1 readable");
    chk("rx1 data", 128'(read_data), 128'({5'd5, 72'h0012345678}));
    read(2'b01);
    chk("rx1 pop readable", 128'(readable), 0);
    chk("rx1 empty data", 128'(read_data), 0);
    // Zero-length frame on channel 1
    push(8'h20);
    wait_rd(2'b10, "rx0len readable");
    chk("rx0len data", 128'(read_data), 0);
    read(2'b10);
    // Backpressure: slot 0 full holds the next frame
    push(8'h01); push(8'h11);
    wait_rd(2'b01, "bp first");
    push(8'h02); push(8'h22); push(8'h33);
    tick(15);
    push(8'h00);
    tick(6);
    chk("bp recv_flag idle", 128'(recv_flag), 0);
    chk("bp byte waiting", 128'(recvable), 1);
    chk("bp old data", 128'(read_data), 128'({5'd1, 72'h11}));
    read(2'b01);
    chk("bp pop+store readable", 128'(readable), 128'(2'b01));
    chk("bp new data", 128'(read_data), 128'({5'd2, 72'h3322}));
    tick(6);
    chk("bp third held", 128'(read_data), 128'({5'd2, 72'h3322}));
    read(2'b01);
    chk("bp third readable", 128'(readable), 128'(2'b01));
    chk("bp third data", 128'(read_data), 0);
    read(2'b01);
    chk("bp drained", 128'(readable), 0);
    // Oversize frame then a normal frame on channel 1
    push(8'h1F);
    for (int i = 0; i < 31; i++) push(8'(i + 1));
    push(8'h21); push(8'hAB);
    wait_rd(2'b11, "big readable");
    chk("big data", 128'(read_data), 128'({5'd9, 72'h090807060504030201}));
    read(2'b01);
    chk("next data", 128'(read_data), 128'({5'd1, 72'hAB}));
    read(2'b10);
    chk("none readable data", 128'(read_data), 0);
    // Reset in the middle of a TX frame
    base = tx_n;
    write(2'b01, {5'd4, 72'h44332211});
    wait_tx(base + 2, "midrst bytes");
    rst = 1'b0;
    #1;
    chk("midrst send_flag", 128'(send_flag), 0);
    chk("midrst send_data", 128'(send_data), 0);
    chk("midrst writable", 128'(writable), 128'(2'b11));
    tick(2);
    rst = 1'b1;
    tick(20);
    chk("midrst no bytes", 128'(tx_n), 128'(base + 2));
    chk("midrst writable after", 128'(writable), 128'(2'b11));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
